// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and defaults for the RAM arbiter slice.
//   AW_DEF / DW_DEF : default RAM address / data widths
//   req_id_e        : requester identity (REQ_A = 0, REQ_B = 1)
//   tag_t           : read-response tag {valid, id} carried down the pipeline
package ram_arb_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 32;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e id;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, id: REQ_A};

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: one requester's req/gnt command bus plus its read-response
// return path.
//   req    requester -> arbiter  access request, held until accepted
//   we     requester -> arbiter  1 = write, 0 = read
//   addr   requester -> arbiter  word address
//   wdata  requester -> arbiter  write data
//   gnt    arbiter -> requester  combinational grant
//   rvalid arbiter -> requester  one-cycle read-data strobe
//   rdata  arbiter -> requester  read data, valid while rvalid is high
// Modports: master = requester side, slave = arbiter side.
interface ram_arbiter_if #(
  parameter int AW = ram_arb_pkg::AW_DEF,
  parameter int DW = ram_arb_pkg::DW_DEF
) ();

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way grant logic for the RAM arbiter.
//   clk, rst_n     clock / asynchronous active-low reset
//   req_a, req_b   requests
//   gnt_a, gnt_b   combinational grants (at most one high)
//   win_id         identity of the granted requester (REQ_A when none)
// Build option RAM_ARB_RR_EN: when defined, conflicts are resolved round-robin
// through the `last` register (reset to REQ_B so A wins the first conflict);
// when undefined, A always beats B and no state is kept.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    req_a,
  input  logic    req_b,
  output logic    gnt_a,
  output logic    gnt_b,
  output req_id_e win_id
);

`ifdef RAM_ARB_RR_EN
  req_id_e last;

  // On conflict the requester that did not win most recently goes first.
  always_comb begin
    gnt_a = req_a & (~req_b | (last == REQ_B));
    gnt_b = req_b & (~req_a | (last == REQ_A));
  end

  // A grant is always an acceptance, so the pointer follows the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= REQ_B;
    end else if (gnt_a) begin
      last <= REQ_A;
    end else if (gnt_b) begin
      last <= REQ_B;
    end
  end
`else
  always_comb begin
    gnt_a = req_a;
    gnt_b = req_b & ~req_a;
  end

  // Fixed priority is stateless; clock and reset are intentionally unused.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;
`endif

  assign win_id = gnt_b ? REQ_B : REQ_A;

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between requesters A and
// B. The winning command is registered onto the RAM pins; read data returns
// to its owner through a two-stage {valid, id} tag pipeline.
//   clk, rst_n  clock / asynchronous active-low reset
//   a, b        requester buses (ram_arbiter_if.slave)
//   ram_cen     RAM chip enable
//   ram_wen     RAM write enable
//   ram_addr    RAM address
//   ram_din     RAM write data
//   ram_dout    RAM registered read data (zero on write / idle cycles)
// Build option RAM_ARB_RR_EN selects round-robin (defined) or fixed A-first
// (undefined) arbitration inside rr_arb2.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_arbiter_if.slave  a,
  ram_arbiter_if.slave  b,
  output logic          ram_cen,
  output logic          ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  logic          gnt_a;
  logic          gnt_b;
  logic          accept_p0;
  req_id_e       win_id_p0;
  logic          we_p0;
  logic [AW-1:0] addr_p0;
  logic [DW-1:0] wdata_p0;
  tag_t          tag_p1;
  tag_t          tag_p2;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_a  (a.req),
    .req_b  (b.req),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .win_id (win_id_p0)
  );

  assign a.gnt     = gnt_a;
  assign b.gnt     = gnt_b;
  assign accept_p0 = gnt_a | gnt_b;

  always_comb begin
    we_p0    = a.we;
    addr_p0  = a.addr;
    wdata_p0 = a.wdata;
    if (win_id_p0 == REQ_B) begin
      we_p0    = b.we;
      addr_p0  = b.addr;
      wdata_p0 = b.wdata;
    end
  end

  // ---- p0 -> p1: accept edge, command onto RAM pins, read tag enters p1 ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cen  <= 1'b0;
      ram_wen  <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      tag_p1   <= TAG_IDLE;
    end else begin
      ram_cen       <= accept_p0;
      ram_wen       <= accept_p0 & we_p0;
      tag_p1.valid  <= accept_p0 & ~we_p0;
      tag_p1.id     <= win_id_p0;
      if (accept_p0) begin
        ram_addr <= addr_p0;
        ram_din  <= wdata_p0;
      end
    end
  end

  // ---- p1 -> p2: RAM captures the read at this same edge ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_p2 <= TAG_IDLE;
    end else begin
      tag_p2 <= tag_p1;
    end
  end

  // ---- p2 -> response: only a valid tag forwards ram_dout, so the RAM's
  // zeroed output on write/idle cycles never reaches a requester ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a.rvalid <= 1'b0;
      b.rvalid <= 1'b0;
      a.rdata  <= '0;
      b.rdata  <= '0;
    end else begin
      a.rvalid <= tag_p2.valid & (tag_p2.id == REQ_A);
      b.rvalid <= tag_p2.valid & (tag_p2.id == REQ_B);
      if (tag_p2.valid && tag_p2.id == REQ_A) begin
        a.rdata <= ram_dout;
      end
      if (tag_p2.valid && tag_p2.id == REQ_B) begin
        b.rdata <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a behavioural 32x32 RAM
// whose reset contents are mem[i] = 1 << i.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ram_cen;
  logic        ram_wen;
  logic [4:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  ram_arbiter_if #(.AW(5), .DW(32)) a_if ();
  ram_arbiter_if #(.AW(5), .DW(32)) b_if ();

  ram_arbiter #(.AW(5), .DW(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a_if),
    .b        (b_if),
    .ram_cen  (ram_cen),
    .ram_wen  (ram_wen),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: registered read, zero output otherwise.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h1 << i;
      ram_dout <= '0;
    end else begin
      if (ram_cen && ram_wen) mem[ram_addr] <= ram_din;
      ram_dout <= (ram_cen && !ram_wen) ? mem[ram_addr] : 32'h0;
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Expected responses indexed by the cycle in which rvalid must be high.
  logic        ea_v [256];
  logic [31:0] ea_d [256];
  logic        eb_v [256];
  logic [31:0] eb_d [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock, then compare both response ports to the schedule.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check($sformatf("a_rvalid@%0d", cyc), {31'b0, a_if.rvalid}, {31'b0, ea_v[cyc]});
    if (ea_v[cyc]) check($sformatf("a_rdata@%0d", cyc), a_if.rdata, ea_d[cyc]);
    check($sformatf("b_rvalid@%0d", cyc), {31'b0, b_if.rvalid}, {31'b0, eb_v[cyc]});
    if (eb_v[cyc]) check($sformatf("b_rdata@%0d", cyc), b_if.rdata, eb_d[cyc]);
  endtask

  task automatic idle_reqs();
    a_if.req = 1'b0;
    b_if.req = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ea_v[i] = 1'b0; ea_d[i] = '0; eb_v[i] = 1'b0; eb_d[i] = '0;
    end
    rst_n = 1'b0;
    a_if.req = 0; a_if.we = 0; a_if.addr = 0; a_if.wdata = 0;
    b_if.req = 0; b_if.we = 0; b_if.addr = 0; b_if.wdata = 0;
    tick();
    tick();

    // Reset state
    check("rst ram_cen", {31'b0, ram_cen}, 32'h0);
    check("rst ram_wen", {31'b0, ram_wen}, 32'h0);
    check("rst ram_addr", {27'b0, ram_addr}, 32'h0);
    check("rst ram_din", ram_din, 32'h0);
    check("rst a_rdata", a_if.rdata, 32'h0);
    check("rst b_rdata", b_if.rdata, 32'h0);
    check("rst a_gnt", {31'b0, a_if.gnt}, 32'h0);
    rst_n = 1'b1;

    // A writes addr 3
    a_if.req = 1; a_if.we = 1; a_if.addr = 5'd3; a_if.wdata = 32'hDEAD_BEEF;
    #1;
    check("wr a_gnt", {31'b0, a_if.gnt}, 32'h1);
    check("wr b_gnt", {31'b0, b_if.gnt}, 32'h0);
    tick();
    check("wr ram_cen", {31'b0, ram_cen}, 32'h1);
    check("wr ram_wen", {31'b0, ram_wen}, 32'h1);
    check("wr ram_addr", {27'b0, ram_addr}, 32'h3);
    check("wr ram_din", ram_din, 32'hDEAD_BEEF);

    // A reads addr 3 right after the write
    a_if.we = 0;
    #1;
    check("rd a_gnt", {31'b0, a_if.gnt}, 32'h1);
    ea_v[cyc + 3] = 1'b1; ea_d[cyc + 3] = 32'hDEAD_BEEF;
    tick();
    check("rd ram_cen", {31'b0, ram_cen}, 32'h1);
    check("rd ram_wen", {31'b0, ram_wen}, 32'h0);
    idle_reqs();
    tick();
    check("idle ram_cen", {31'b0, ram_cen}, 32'h0);
    for (int i = 0; i < 3; i++) tick();

    // Conflict: reset first so A wins the first conflict
    pulse_reset();
    a_if.req = 1; a_if.we = 0; a_if.addr = 5'd1;
    b_if.req = 1; b_if.we = 0; b_if.addr = 5'd2;
    for (int k = 0; k < 6; k++) begin
      #1;
`ifdef RAM_ARB_RR_EN
      check($sformatf("conf a_gnt%0d", k), {31'b0, a_if.gnt}, (k % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("conf b_gnt%0d", k), {31'b0, b_if.gnt}, (k % 2 == 1) ? 32'h1 : 32'h0);
      if (k % 2 == 0) begin
        ea_v[cyc + 3] = 1'b1; ea_d[cyc + 3] = 32'h2;
      end else begin
        eb_v[cyc + 3] = 1'b1; eb_d[cyc + 3] = 32'h4;
      end
`else
      check($sformatf("conf a_gnt%0d", k), {31'b0, a_if.gnt}, 32'h1);
      check($sformatf("conf b_gnt%0d", k), {31'b0, b_if.gnt}, 32'h0);
      ea_v[cyc + 3] = 1'b1; ea_d[cyc + 3] = 32'h2;
`endif
      tick();
    end
    idle_reqs();
    for (int i = 0; i < 4; i++) tick();

    // Reset one cycle after a read is accepted
    b_if.req = 1; b_if.we = 0; b_if.addr = 5'd7;
    #1;
    check("mid b_gnt", {31'b0, b_if.gnt}, 32'h1);
    tick();
    idle_reqs();
    rst_n = 1'b0;
    #1;
    check("mid ram_cen", {31'b0, ram_cen}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("mid ram_cen after", {31'b0, ram_cen}, 32'h0);

    // B reads addr 0..31 back to back
    b_if.req = 1; b_if.we = 0;
    for (int k = 0; k < 32; k++) begin
      b_if.addr = k[4:0];
      #1;
      check($sformatf("b2b b_gnt%0d", k), {31'b0, b_if.gnt}, 32'h1);
      eb_v[cyc + 3] = 1'b1; eb_d[cyc + 3] = 32'h1 << k;
      tick();
    end
    idle_reqs();
    for (int i = 0; i < 4; i++) tick();

    // A writes addr 5, B reads addr 5 the next cycle
    a_if.req = 1; a_if.we = 1; a_if.addr = 5'd5; a_if.wdata = 32'h1234;
    #1;
    check("il a_gnt", {31'b0, a_if.gnt}, 32'h1);
    tick();
    a_if.req = 0;
    b_if.req = 1; b_if.we = 0; b_if.addr = 5'd5;
    #1;
    check("il b_gnt", {31'b0, b_if.gnt}, 32'h1);
    eb_v[cyc + 3] = 1'b1; eb_d[cyc + 3] = 32'h1234;
    tick();
    idle_reqs();
    for (int i = 0; i < 4; i++) tick();
    check("il b_rdata hold", b_if.rdata, 32'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port 32x32 synchronous RAM between requesters A and B. Each requester uses a req/gnt handshake. The arbiter registers the winning command onto the RAM control pins and returns read data to the owning requester through a tagged two-stage pipeline. It sits directly in front of the RAM instance and is the only driver of its cen/wen/addr/din pins.

## Interface
- AW, 5: RAM address width.
- DW, 32: RAM data width.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req / b_req  in  1  access request; held with its command fields until accepted.
- a_we / b_we  in  1  1 = write, 0 = read.
- a_addr / b_addr  in  AW  word address.
- a_wdata / b_wdata  in  DW  write data.
- a_gnt / b_gnt  out  1  combinational grant; accepted at the edge where req & gnt.
- a_rvalid / b_rvalid  out  1  registered one-cycle read-data strobe.
- a_rdata / b_rdata  out  DW  registered read data; valid only while rvalid is high.
- ram_cen  out  1  RAM chip enable.
- ram_wen  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_din  out  DW  RAM write data.
- ram_dout  in  DW  RAM registered read data (RAM zeroes it on write and on idle cycles).

## Operation
- At most one access is accepted per cycle. Sustained throughput is 1 access/cycle.
- Grant (combinational from req and the priority pointer `last`):
  - Only one requester asserting req: that requester is granted.
  - Both asserting req: grant goes to the requester that is not `last`.
  - `last` updates to the accepted requester on every acceptance.
- Accept edge E0: ram_cen=1, ram_wen=we, ram_addr=addr, ram_din=wdata are registered from the winner. With no acceptance, ram_cen=0, ram_wen=0, and addr/din hold.
- Read pipeline: a read acceptance pushes {valid, id} into tag stage s1 at E0. s1 moves to s2 at E1, when the RAM captures dout.
- At E2, if s2 is valid: rdata[id] <= ram_dout and rvalid[id] <= 1. All other rvalid bits are 0.
- Writes produce no response. rdata of the non-owning port holds its last value.
- Ordering: a read accepted the cycle after a write to the same address returns the new data.
- The RAM's zeroed dout on write/idle cycles is never forwarded, because capture happens only on a valid s2 tag.
- Reset: all outputs and state are cleared.
  - ram_cen=0, ram_wen=0, ram_addr=0, ram_din=0.
  - rvalid=0, rdata=0 on both ports.
  - s1/s2 invalid; `last`=B, so A wins the first conflict.
  - Reset asserted mid-operation discards in-flight reads; no rvalid is produced for them.

## Timing
- Grant: same cycle as req, combinational. No registered path from req to gnt.
- Write: RAM updated at E1, one edge after the accept edge.
- Read: rvalid/rdata high for exactly the cycle following E2. Request-to-data latency is 3 cycles, counting the accept cycle as cycle 0.
- A requester may hold req high across consecutive acceptances. Each req&gnt edge is one transaction.
- Command fields must be stable while req=1 and gnt=0.

## Configuration
- RAM_ARB_RR_EN defined: round-robin arbitration via `last`, as described above.
- RAM_ARB_RR_EN undefined: fixed priority, A always beats B. `last` is not implemented. B can starve under continuous A traffic. All other behaviour is identical.

## Structure
- Package ram_arb_pkg holds:
  - AW/DW defaults.
  - Requester id enum REQ_A=0, REQ_B=1.
  - Tag struct {valid, id}.
- Sub-module rr_arb2: 2-way grant logic plus the `last` register, with the RAM_ARB_RR_EN switch local to it.
- The top level holds the command register, the tag pipeline and the response registers.

## Test plan
- Reset: check every output is 0 under reset. Release rst_n. A writes addr 3 = 32'hDEAD_BEEF with b_req=0 -> a_gnt=1 same cycle, ram_cen=1 and ram_wen=1 next cycle.
- A reads addr 3 immediately after that write -> a_rvalid=1 with a_rdata=32'hDEAD_BEEF, 3 cycles after the accept cycle; b_rvalid stays 0.
- Conflict: A and B both read continuously from addr 1 and addr 2 (initial RAM contents) for 6 cycles.
  - RR_EN defined: grants alternate A,B,A,B,A,B. Responses arrive 32'h2, 32'h4 alternately, in order, on the correct ports.
  - RR_EN undefined: all 6 grants go to A.
- Back-to-back reads by B of addr 0..31 -> 32 consecutive b_rvalid cycles returning 1<<addr, no bubbles.
- Reset asserted one cycle after a read is accepted, then released -> no rvalid on either port, ram_cen=0.
- Interleave: A writes addr 5 = 32'h1234 while B reads addr 5 in the next cycle -> b_rdata=32'h1234.
